// File: rtl/sub_seq_pkg.sv
// Shared types and constants for the serial subtract sequencer.
package sub_seq_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } sub_seq_state_t;

   localparam int SLICE_DEFAULT = 4;

   // A single-slice build still needs a 1-bit index register.
   function automatic int idx_width(input int nslice);
      return (nslice > 1) ? $clog2(nslice) : 1;
   endfunction

endpackage

// File: rtl/nibble_sub_slice.sv
// Combinational SLICE-bit slice computing {cout, s} = a + ~b + cin.
module nibble_sub_slice #(
   parameter int SLICE = 4
) (
   input  logic [SLICE-1:0] a,
   input  logic [SLICE-1:0] b,
   input  logic             cin,
   output logic [SLICE-1:0] s,
   output logic             cout
);

   logic [SLICE:0] w_sum;

   // ~b sits inside a concatenation so it inverts at SLICE bits, not at the
   // widened SLICE+1 context width, which would set a spurious carry bit.
   assign w_sum = {1'b0, a} + {1'b0, ~b} + {{SLICE{1'b0}}, cin};
   assign s     = w_sum[SLICE-1:0];
   assign cout  = w_sum[SLICE];

endmodule

// File: rtl/serial_subtract_sequencer.sv
// Multi-cycle WIDTH-bit subtractor reusing one SLICE-bit slice, LSB slice first.
// Define SUB_SEQ_OVF_EN to add the registered signed-overflow output ovf.
module serial_subtract_sequencer
   import sub_seq_pkg::*;
#(
   parameter int WIDTH = 16,
   parameter int SLICE = SLICE_DEFAULT
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] diff,
   output logic             cout,
   output logic             zero
`ifdef SUB_SEQ_OVF_EN
   ,
   output logic             ovf
`endif
);

   localparam int NSLICE = WIDTH / SLICE;
   localparam int IDX_W  = idx_width(NSLICE);
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NSLICE - 1);

   sub_seq_state_t   r_state;
   logic [WIDTH-1:0] r_a;
   logic [WIDTH-1:0] r_b;
   logic [WIDTH-1:0] r_diff;
   logic [IDX_W-1:0] r_idx;
   logic             r_carry;
   logic             r_cout;
   logic             r_zero;
   logic             r_out_valid;
`ifdef SUB_SEQ_OVF_EN
   logic             r_ovf;
`endif

   logic [SLICE-1:0] w_a_sl;
   logic [SLICE-1:0] w_b_sl;
   logic [SLICE-1:0] w_s;
   logic             w_c;
   logic [WIDTH-1:0] w_diff_next;
   logic             w_accept;

   assign w_accept = (r_state == IDLE) && in_valid;
   assign w_a_sl   = r_a[r_idx*SLICE +: SLICE];
   assign w_b_sl   = r_b[r_idx*SLICE +: SLICE];

   nibble_sub_slice #(.SLICE(SLICE)) u_slice (
      .a    (w_a_sl),
      .b    (w_b_sl),
      .cin  (r_carry),
      .s    (w_s),
      .cout (w_c)
   );

   // NOTE: give every always_comb output a full default before any partial
   // update; otherwise untouched bits hold their old value and infer a latch.
   always_comb begin
      w_diff_next = r_diff;
      w_diff_next[r_idx*SLICE +: SLICE] = w_s;
   end

   // NOTE: operand registers carry no reset; they are only read after a
   // handshake has loaded them, so a reset would buy nothing.
   always_ff @(posedge clk) begin
      if (w_accept) begin
         r_a <= a;
         r_b <= b;
      end
   end

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples pre-edge values, independent of statement order.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state     <= IDLE;
         r_idx       <= '0;
         r_diff      <= '0;
         r_carry     <= 1'b0;
         r_cout      <= 1'b0;
         r_zero      <= 1'b0;
         r_out_valid <= 1'b0;
`ifdef SUB_SEQ_OVF_EN
         r_ovf       <= 1'b0;
`endif
      end else begin
         case (r_state)
            IDLE: begin
               if (in_valid) begin
                  r_carry <= 1'b1;
                  r_idx   <= '0;
                  r_state <= RUN;
               end
            end
            RUN: begin
               r_diff  <= w_diff_next;
               r_carry <= w_c;
               if (r_idx == LAST_IDX) begin
                  r_idx       <= '0;
                  r_cout      <= w_c;
                  r_zero      <= (w_diff_next == '0);
                  r_out_valid <= 1'b1;
`ifdef SUB_SEQ_OVF_EN
                  r_ovf       <= (r_a[WIDTH-1] != r_b[WIDTH-1]) &&
                                 (w_s[SLICE-1] != r_a[WIDTH-1]);
`endif
                  r_state     <= DONE;
               end else begin
                  r_idx <= r_idx + 1'b1;
               end
            end
            DONE: begin
               // Result is held until the consumer takes it; zero is only
               // meaningful while out_valid is high.
               if (out_ready) begin
                  r_out_valid <= 1'b0;
                  r_zero      <= 1'b0;
                  r_state     <= IDLE;
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   assign in_ready  = (r_state == IDLE);
   assign out_valid = r_out_valid;
   assign diff      = r_diff;
   assign cout      = r_cout;
   assign zero      = r_zero;
`ifdef SUB_SEQ_OVF_EN
   assign ovf       = r_ovf;
`endif

endmodule

// File: tb/tb_serial_subtract_sequencer.sv
// Self-checking bench for serial_subtract_sequencer (WIDTH=16, SLICE=4).
// Checks ovf as well when SUB_SEQ_OVF_EN is defined.
module tb_serial_subtract_sequencer;

   localparam int WIDTH   = 16;
   localparam int SLICE   = 4;
   localparam int NSLICE  = WIDTH / SLICE;

   logic             clk = 1'b0;
   logic             rst = 1'b1;
   logic             in_valid = 1'b0;
   logic             in_ready;
   logic [WIDTH-1:0] a = '0;
   logic [WIDTH-1:0] b = '0;
   logic             out_valid;
   logic             out_ready = 1'b0;
   logic [WIDTH-1:0] diff;
   logic             cout;
   logic             zero;
`ifdef SUB_SEQ_OVF_EN
   logic             ovf;
`endif

   int total = 0;
   int bad   = 0;

   serial_subtract_sequencer #(.WIDTH(WIDTH), .SLICE(SLICE)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a),
      .b         (b),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .diff      (diff),
      .cout      (cout),
      .zero      (zero)
`ifdef SUB_SEQ_OVF_EN
      ,
      .ovf       (ovf)
`endif
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Issue one subtraction, hold the result for `hold` cycles with out_ready
   // low (poking in_valid meanwhile), then retire it. Expectations come from
   // plain integer arithmetic on the operands.
   task automatic do_op(input logic [WIDTH-1:0] ta, input logic [WIDTH-1:0] tb_v,
                        input int hold, input string tag);
      logic [WIDTH-1:0] exp_diff;
      logic             exp_cout;
      int               sdiff;
      int               n;
      bit               got;
      logic [WIDTH-1:0] held_diff;

      exp_diff = WIDTH'((int'(ta) - int'(tb_v) + 65536) % 65536);
      exp_cout = (int'(ta) >= int'(tb_v));
      sdiff    = int'($signed(ta)) - int'($signed(tb_v));

      @(negedge clk);
      check({tag, ".in_ready_idle"}, 32'(in_ready), 32'd1);
      a = ta; b = tb_v; in_valid = 1'b1;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      a = WIDTH'($urandom);
      b = WIDTH'($urandom);

      n = 0; got = 0;
      while (!got && n < 3 * NSLICE) begin
         @(posedge clk);
         n++;
         @(negedge clk);
         if (out_valid === 1'b1) got = 1;
      end
      check({tag, ".latency"}, 32'(n), 32'(NSLICE));
      check({tag, ".diff"}, 32'(diff), 32'(exp_diff));
      check({tag, ".cout"}, 32'(cout), 32'(exp_cout));
      check({tag, ".zero"}, 32'(zero), 32'(exp_diff == '0));
      check({tag, ".in_ready_busy"}, 32'(in_ready), 32'd0);
`ifdef SUB_SEQ_OVF_EN
      check({tag, ".ovf"}, 32'(ovf), 32'(sdiff > 32767 || sdiff < -32768));
`endif

      held_diff = diff;
      for (int i = 0; i < hold; i++) begin
         in_valid = 1'b1;
         a = WIDTH'($urandom);
         b = WIDTH'($urandom);
         @(negedge clk);
         check({tag, ".hold_valid"}, 32'(out_valid), 32'd1);
         check({tag, ".hold_diff"}, 32'(diff), 32'(held_diff));
         check({tag, ".hold_cout"}, 32'(cout), 32'(exp_cout));
         check({tag, ".hold_zero"}, 32'(zero), 32'(exp_diff == '0));
         check({tag, ".hold_in_ready"}, 32'(in_ready), 32'd0);
      end
      in_valid = 1'b0;

      out_ready = 1'b1;
      @(posedge clk);
      #1;
      out_ready = 1'b0;
      @(negedge clk);
      check({tag, ".retired_valid"}, 32'(out_valid), 32'd0);
      check({tag, ".retired_in_ready"}, 32'(in_ready), 32'd1);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation exceeded its time limit");
      $fatal(1, "watchdog");
   end

   initial begin
      // Reset state
      #12;
      check("rst.in_ready", 32'(in_ready), 32'd1);
      check("rst.out_valid", 32'(out_valid), 32'd0);
      check("rst.diff", 32'(diff), 32'd0);
      check("rst.cout", 32'(cout), 32'd0);
      check("rst.zero", 32'(zero), 32'd0);
`ifdef SUB_SEQ_OVF_EN
      check("rst.ovf", 32'(ovf), 32'd0);
`endif
      @(negedge clk);
      rst = 1'b0;

      // Directed vectors
      do_op(16'h1234, 16'h0235, 0, "t1");
      do_op(16'h0100, 16'h0001, 0, "t2_ripple");
      do_op(16'h0000, 16'h0001, 0, "t3_borrow");
      do_op(16'h8000, 16'h0001, 0, "t3_ovf");
      do_op(16'hA5A5, 16'hA5A5, 0, "t4_zero");
      do_op(16'hFFFF, 16'h0000, 0, "max_minus_0");
      do_op(16'h7FFF, 16'hFFFF, 0, "pos_minus_neg");

      // Backpressure in DONE
      do_op(16'h4321, 16'h1234, 3, "t5_hold");

      // Reset while the slice index is 2
      @(negedge clk);
      a = 16'h5555; b = 16'h1111; in_valid = 1'b1;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      @(posedge clk);
      @(posedge clk);
      #2;
      rst = 1'b1;
      #2;
      rst = 1'b0;
      @(negedge clk);
      check("t6.out_valid", 32'(out_valid), 32'd0);
      check("t6.in_ready", 32'(in_ready), 32'd1);
      check("t6.diff", 32'(diff), 32'd0);
      for (int i = 0; i < NSLICE + 2; i++) begin
         @(negedge clk);
         check("t6.no_result", 32'(out_valid), 32'd0);
      end
      do_op(16'h0010, 16'h0001, 0, "t6_after");

      // Randomized operands against integer arithmetic
      for (int i = 0; i < 24; i++) begin
         do_op(WIDTH'($urandom), WIDTH'($urandom), int'($urandom_range(0, 2)), "rand");
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
